// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory behind a valid/ready request port.
// Byte, halfword and word accesses with sign/zero extension on loads.
// A fixed number of wait states is applied per access. Misaligned, illegal-size
// and out-of-range accesses fault without touching the array.
module data_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    // With no wait states the access commits on the acceptance edge, so it
    // must use the live request fields instead of the latched copy.
    localparam bit DIRECT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic        lat_we, lat_uns;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        accept, commit;
    logic        a_we, a_uns, a_fault;
    logic [1:0]  a_size, a_lane;
    logic [31:0] a_addr, a_wdata;
    logic [29:0] a_idx;
    logic [3:0]  be;
    logic [31:0] wd, word, ld;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = req_valid && req_ready;
    assign commit = DIRECT ? accept : (state_q == ST_WAIT && cnt_q == 3'd0);

    // Select the fields of the access that commits this cycle
    always_comb begin
        a_we    = DIRECT ? req_we       : lat_we;
        a_uns   = DIRECT ? req_unsigned : lat_uns;
        a_size  = DIRECT ? req_size     : lat_size;
        a_addr  = DIRECT ? req_addr     : lat_addr;
        a_wdata = DIRECT ? req_wdata    : lat_wdata;
        a_idx   = a_addr[31:2];
        a_lane  = a_addr[1:0];
        a_fault = (a_size == 2'b11)
               || (a_size == 2'b01 && a_addr[0])
               || (a_size == 2'b10 && a_lane != 2'b00)
               || (a_idx >= 30'(DEPTH));
    end

    // Build lane enables and replicated store data, and extract/extend load data
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        be      = 4'b0000;
        wd      = a_wdata;
        ld      = '0;
        word    = mem[a_idx[AW-1:0]];
        ld_byte = word[{a_lane, 3'b000} +: 8];
        ld_half = a_lane[1] ? word[31:16] : word[15:0];
        case (a_size)
            2'b00: begin
                be = 4'b0001 << a_lane;
                wd = {4{a_wdata[7:0]}};
                ld = {{24{~a_uns & ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                be = a_lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
                ld = {{16{~a_uns & ld_half[15]}}, ld_half};
            end
            2'b10: begin
                be = 4'b1111;
                ld = word;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) state_d = DIRECT ? ST_RESP : ST_WAIT;
                else        state_d = ST_IDLE;
            end
            ST_WAIT: if (cnt_q == 3'd0) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = reset && (state_q != ST_WAIT);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_fault = rsp_valid ? fault_q : 1'b0;
        busy      = (state_q == ST_WAIT);
    end

    // Latch request fields on acceptance and run the wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt_q     <= 3'd0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt_q     <= 3'(WAIT_STATES - 1);
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Memory array: lane-masked stores at commit, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is cleared by reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && a_we && !a_fault) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[a_idx[AW-1:0]][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    // Capture the response at the commit edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (commit) begin
            rdata_q <= (a_fault || a_we) ? 32'd0 : ld;
            fault_q <= a_fault;
        end
    end

endmodule
